// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for the APB master bridge.
// The master modport is the bridge. The slave modport is everything that talks
// to it: the command source, the response consumer and the APB completer.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;
  // APB requester side
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester. It takes one command from a valid/ready
// channel, runs one SETUP/ACCESS transfer, and returns read data and error status
// on a valid/ready response channel. A bounded pready wait aborts a hung slave.
module apb_master_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TMO_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_master_bridge_if.master bus
);

  // The counter only has to hold 0..TMO_CYCLES-1.
  localparam int CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              accept;
  logic              complete;
  logic              abort;

  logic              pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;
  logic              rsp_tmo_reg;

  // State and timeout counter. An asynchronous reset returns to IDLE immediately.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic. ACCESS ends on pready or when the wait budget runs out.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        count_next = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (TMO_CYCLES != 0) begin
          if (count_reg == TMO_LAST) begin
            abort      = 1'b1;
            state_next = RESP;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // APB address phase registers. They change only when a new command is accepted.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pwrite_reg <= 1'b0;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
    end else if (accept) begin
      pwrite_reg <= bus.cmd_write;
      paddr_reg  <= bus.cmd_addr & WORD_MASK;
      pwdata_reg <= bus.cmd_wdata;
    end
  end

  // Response registers. They are loaded when ACCESS ends and held through RESP.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_tmo_reg   <= 1'b0;
    end else if (complete) begin
      rsp_rdata_reg <= pwrite_reg ? '0 : bus.prdata;
      rsp_err_reg   <= bus.pslverr;
      rsp_tmo_reg   <= 1'b0;
    end else if (abort) begin
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b1;
      rsp_tmo_reg   <= 1'b1;
    end
  end

  // Handshake and APB phase outputs are decoded straight from the state, so reset
  // clears them without waiting for a clock edge.
  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.psel      = (state_reg == SETUP) || (state_reg == ACCESS);
  assign bus.penable   = (state_reg == ACCESS);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.pwrite    = pwrite_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwdata    = pwdata_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_tmo   = rsp_tmo_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge. It runs directed transfers against an APB slave
// stub. A timing and data model checks every cycle, and literal per-transfer
// expectations pin the model.
module tb_apb_master_bridge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYCLES(TMO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // APB slave stub: 8 words at 0x00..0x1C; anything above returns pslverr.
  // pready is held low for slv_waits ACCESS cycles.
  logic [31:0] slv_mem [8] = '{default: 32'h0};
  logic [7:0]  acc_cnt = 8'd0;
  int          slv_waits = 0;
  logic        slv_mapped;
  assign slv_mapped  = (bus.paddr < 32'h20);
  assign bus.pready  = bus.psel && bus.penable && (int'(acc_cnt) >= slv_waits);
  assign bus.pslverr = bus.psel && bus.penable && !slv_mapped;
  assign bus.prdata  = (bus.psel && bus.penable && slv_mapped && !bus.pwrite)
                       ? slv_mem[bus.paddr[4:2]] : 32'h0;
  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 8'd1;
    else acc_cnt <= 8'd0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && slv_mapped)
      slv_mem[bus.paddr[4:2]] <= bus.pwdata;
  end

  // Transaction model. Cycle xs is the accept cycle, and ACCESS lasts a_len cycles.
  // The response is held r_len extra cycles.
  bit          act = 1'b0;
  int          xs = 0, a_len = 1, r_len = 0;
  logic [31:0] m_paddr, m_pwdata, m_rdata;
  logic        m_pwrite, m_err, m_tmo;
  logic [31:0] model_mem [8] = '{default: 32'h0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Per-cycle compare of bus phases, handshakes and data against the model.
  always @(negedge pclk) begin
    bit e_psel, e_pen, e_rv, e_cr;
    int c;
    c = cyc;
    e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0; e_cr = 1'b1;
    if (act) begin
      e_psel = (c >= xs + 1) && (c <= xs + 1 + a_len);
      e_pen  = (c >= xs + 2) && (c <= xs + 1 + a_len);
      e_rv   = (c >= xs + 2 + a_len) && (c <= xs + 2 + a_len + r_len);
      e_cr   = !((c >= xs + 1) && (c <= xs + 2 + a_len + r_len));
    end
    check("psel", 32'(bus.psel), 32'(e_psel));
    check("penable", 32'(bus.penable), 32'(e_pen));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    check("cmd_ready", 32'(bus.cmd_ready), 32'(e_cr));
    if (act && c >= xs + 1) begin
      check("paddr", bus.paddr, m_paddr);
      check("pwrite", 32'(bus.pwrite), 32'(m_pwrite));
      check("pwdata", bus.pwdata, m_pwdata);
    end
    if (e_rv) begin
      check("rsp_rdata", bus.rsp_rdata, m_rdata);
      check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      check("rsp_tmo", 32'(bus.rsp_tmo), 32'(m_tmo));
    end
  end

  // Loads the model for one command accepted in the current cycle.
  task automatic model_load(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input int dly);
    logic [31:0] aligned;
    bit timed_out;
    int idx;
    aligned   = addr & ~32'h3;
    timed_out = (waits + 1) > TMO;
    idx       = int'(aligned[4:2]);
    m_paddr   = aligned;
    m_pwrite  = wr;
    m_pwdata  = wdata;
    if (timed_out) begin
      m_rdata = 32'h0; m_err = 1'b1; m_tmo = 1'b1;
    end else if (aligned >= 32'h20) begin
      m_rdata = 32'h0; m_err = 1'b1; m_tmo = 1'b0;
    end else begin
      m_err = 1'b0; m_tmo = 1'b0;
      m_rdata = wr ? 32'h0 : model_mem[idx];
      if (wr) model_mem[idx] = wdata;
    end
    slv_waits = waits;
    a_len = timed_out ? TMO : waits + 1;
    r_len = dly;
    xs = cyc;
    act = 1'b1;
  endtask

  // One transfer, started in an IDLE cycle (posedge+1) and returning in the next
  // IDLE cycle. The slave inserts 'waits' wait states, and the consumer stalls
  // 'dly' cycles. With junk=1 a stray command is held on cmd_* while the bridge is busy.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input int dly, input bit junk,
                       input logic [31:0] lit_rdata, input logic lit_err, input logic lit_tmo);
    model_load(wr, addr, wdata, waits, dly);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    if (junk) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h18;
      bus.cmd_wdata = 32'hDEAD_BEEF;
    end
    while (cyc < xs + 2 + a_len + r_len) begin
      @(posedge pclk); #1;
    end
    check("lit_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("lit_rsp_rdata", bus.rsp_rdata, lit_rdata);
    check("lit_rsp_err", 32'(bus.rsp_err), 32'(lit_err));
    check("lit_rsp_tmo", 32'(bus.rsp_tmo), 32'(lit_tmo));
    $display("xfer %s addr=0x%08h wdata=0x%08h waits=%0d stall=%0d -> rdata=0x%08h err=%0b tmo=%0b",
             wr ? "WR" : "RD", addr, wdata, waits, dly, bus.rsp_rdata, bus.rsp_err, bus.rsp_tmo);
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    @(posedge pclk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    preset_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_psel", 32'(bus.psel), 32'h0);
    check("rst_penable", 32'(bus.penable), 32'h0);
    check("rst_pwrite", 32'(bus.pwrite), 32'h0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_rsp_tmo", 32'(bus.rsp_tmo), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    preset_n = 1'b1;
    @(posedge pclk); #1;

    // write then read back, minimum latency
    issue(1'b1, 32'h08, 32'h0000_00A5, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h08, 32'h0, 0, 0, 1'b0, 32'h0000_00A5, 1'b0, 1'b0);
    // unmapped read -> slave error
    issue(1'b0, 32'h20, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    // hung slave -> timeout after 16 ACCESS cycles, then 3 wait states completes
    issue(1'b0, 32'h00, 32'h0, 100, 0, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h0B, 32'h0, 3, 0, 1'b0, 32'h0000_00A5, 1'b0, 1'b0);
    // stalled consumer with a stray command pending, then immediate next command
    issue(1'b1, 32'h0C, 32'h1234_5678, 0, 5, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h0C, 32'h0, 0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    // the last wait state gives an ACCESS of exactly 16 cycles with no timeout
    issue(1'b0, 32'h0C, 32'h0, 15, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

    // reset in the middle of ACCESS
    model_load(1'b0, 32'h08, 32'h0, 5, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h08;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge pclk); #2;
    preset_n = 1'b0;
    act = 1'b0;
    #1;
    check("arst_psel", 32'(bus.psel), 32'h0);
    check("arst_penable", 32'(bus.penable), 32'h0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    $display("xfer RD addr=0x00000008 aborted by reset");
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 1'b1;
    @(posedge pclk); #1;
    issue(1'b1, 32'h04, 32'h7654_3210, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h04, 32'h0, 1, 0, 1'b0, 32'h7654_3210, 1'b0, 1'b0);

    // back-to-back writes and reads, one transfer every four cycles
    issue(1'b1, 32'h10, 32'hAAAA_5555, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 32'h14, 32'h0F0F_0F0F, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 0, 0, 1'b0, 32'hAAAA_5555, 1'b0, 1'b0);
    issue(1'b0, 32'h14, 32'h0, 0, 0, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0);

    repeat (3) @(posedge pclk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
